// File: rtl/cdb_arbiter.sv
// Common Data Bus writeback arbiter.
// Picks one functional-unit result per cycle in round-robin order, registers it
// onto the CDB, and stalls every other requesting FU so it holds its result
// until it wins. Losing requests are never buffered here; the FUs hold them.
module cdb_arbiter #(
    parameter int NUM_FU     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_flush,
    input  logic [NUM_FU-1:0]              i_fu_valid,
    input  logic [NUM_FU*DATA_WIDTH-1:0]   i_fu_data,
    input  logic [NUM_FU*PREG_WIDTH-1:0]   i_fu_prd,
    input  logic [NUM_FU*ROB_WIDTH-1:0]    i_fu_rob_tag,
    output logic [NUM_FU-1:0]              o_fu_stall,
    output logic                           o_cdb_valid,
    output logic [DATA_WIDTH-1:0]          o_cdb_data,
    output logic [PREG_WIDTH-1:0]          o_cdb_prd,
    output logic [ROB_WIDTH-1:0]           o_cdb_rob_tag,
    output logic [$clog2(NUM_FU)-1:0]      o_cdb_fu_id
);

    localparam int                ID_W    = $clog2(NUM_FU);
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_FU - 1);

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       scan_idx;
    logic [ID_W-1:0]       win_idx;
    logic [ID_W-1:0]       next_ptr;
    logic [NUM_FU-1:0]     grant;
    logic                  any_grant;
    logic                  take;
    logic [DATA_WIDTH-1:0] win_data;
    logic [PREG_WIDTH-1:0] win_prd;
    logic [ROB_WIDTH-1:0]  win_tag;

    // Round-robin scan starting at rr_ptr; the wrap is an explicit compare so
    // a non-power-of-two FU count never visits a nonexistent index.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        win_idx   = '0;
        scan_idx  = rr_ptr;
        for (int i = 0; i < NUM_FU; i++) begin
            if (!any_grant && i_fu_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                any_grant       = 1'b1;
                win_idx         = scan_idx;
            end
            scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + 1'b1;
        end
    end

    // One-hot select of the winning FU's result fields.
    always_comb begin
        win_data = '0;
        win_prd  = '0;
        win_tag  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (grant[k]) begin
                win_data = i_fu_data[k*DATA_WIDTH +: DATA_WIDTH];
                win_prd  = i_fu_prd[k*PREG_WIDTH +: PREG_WIDTH];
                win_tag  = i_fu_rob_tag[k*ROB_WIDTH +: ROB_WIDTH];
            end
        end
    end

    // A flush cancels the grant; the pointer only moves past a real winner.
    assign take     = any_grant & ~i_flush;
    assign next_ptr = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;

    // Losers stall; flush and reset release everyone so flushed results drain.
    assign o_fu_stall = i_fu_valid & ~grant & {NUM_FU{~i_flush & ~reset}};

    // Broadcast register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_cdb_valid   <= 1'b0;
            o_cdb_data    <= '0;
            o_cdb_prd     <= '0;
            o_cdb_rob_tag <= '0;
            o_cdb_fu_id   <= '0;
            rr_ptr        <= '0;
        end else begin
            o_cdb_valid <= take;
            if (take) begin
                o_cdb_data    <= win_data;
                o_cdb_prd     <= win_prd;
                o_cdb_rob_tag <= win_tag;
                o_cdb_fu_id   <= win_idx;
                rr_ptr        <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by randomized traffic.
// A reference model predicts stalls and broadcasts; expected broadcasts are
// queued and a separate monitor pops them when the CDB presents a result.
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int PW = 7;
    localparam int TW = 4;
    localparam int IW = $clog2(N);

    typedef struct {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        logic [TW-1:0] t;
        int            id;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_flush = 1'b0;
    logic [N-1:0]      i_fu_valid = '0;
    logic [N*DW-1:0]   i_fu_data = '0;
    logic [N*PW-1:0]   i_fu_prd = '0;
    logic [N*TW-1:0]   i_fu_rob_tag = '0;
    logic [N-1:0]      o_fu_stall;
    logic              o_cdb_valid;
    logic [DW-1:0]     o_cdb_data;
    logic [PW-1:0]     o_cdb_prd;
    logic [TW-1:0]     o_cdb_rob_tag;
    logic [IW-1:0]     o_cdb_fu_id;

    cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .PREG_WIDTH(PW), .ROB_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush),
        .i_fu_valid(i_fu_valid), .i_fu_data(i_fu_data), .i_fu_prd(i_fu_prd),
        .i_fu_rob_tag(i_fu_rob_tag), .o_fu_stall(o_fu_stall),
        .o_cdb_valid(o_cdb_valid), .o_cdb_data(o_cdb_data), .o_cdb_prd(o_cdb_prd),
        .o_cdb_rob_tag(o_cdb_rob_tag), .o_cdb_fu_id(o_cdb_fu_id)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t exp_q[$];
    bit   done = 0;

    // FU-side state held by the bench
    logic          fv [N];
    logic [DW-1:0] fd [N];
    logic [PW-1:0] fp [N];
    logic [TW-1:0] ft [N];

    // reference model state
    int           m_rr = 0;
    logic         exp_valid = 1'b0;
    logic [N-1:0] last_stall = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic regen(input int k, input logic v);
        fv[k] = v;
        fd[k] = $urandom;
        fp[k] = PW'($urandom);
        ft[k] = TW'($urandom);
    endtask

    // Drive one cycle: apply FU state, check stalls against the model, advance
    // the model, then check the registered valid after the edge.
    task automatic step(input logic fl, input logic rs);
        int           win;
        logic [N-1:0] es;
        ent_t         e;
        reset   = rs;
        i_flush = fl;
        for (int k = 0; k < N; k++) begin
            i_fu_valid[k]            = fv[k];
            i_fu_data[k*DW +: DW]    = fd[k];
            i_fu_prd[k*PW +: PW]     = fp[k];
            i_fu_rob_tag[k*TW +: TW] = ft[k];
        end
        #1;
        win = -1;
        if (!rs && !fl) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_rr + i) % N;
                if (win < 0 && fv[k]) win = k;
            end
        end
        es = '0;
        for (int k = 0; k < N; k++) es[k] = fv[k] && (k != win) && !fl && !rs;
        chk("fu_stall", 64'(o_fu_stall), 64'(es));
        last_stall = es;
        if (rs) begin
            m_rr      = 0;
            exp_valid = 1'b0;
        end else if (win >= 0) begin
            e.d = fd[win]; e.p = fp[win]; e.t = ft[win]; e.id = win;
            exp_q.push_back(e);
            m_rr      = (win + 1) % N;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("cdb_valid", 64'(o_cdb_valid), 64'(exp_valid));
    endtask

    // Monitor: whenever the CDB presents a result, compare with the oldest prediction.
    initial begin
        ent_t e;
        while (!done) begin
            @(negedge clk);
            if (!done && o_cdb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("cdb_unexpected", 64'(o_cdb_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cdb_data", 64'(o_cdb_data), 64'(e.d));
                    chk("cdb_prd", 64'(o_cdb_prd), 64'(e.p));
                    chk("cdb_rob_tag", 64'(o_cdb_rob_tag), 64'(e.t));
                    chk("cdb_fu_id", 64'(o_cdb_fu_id), 64'(e.id));
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) regen(k, 1'b1);
        @(posedge clk); #1;

        // reset held two cycles with every FU valid
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_data", 64'(o_cdb_data), 64'd0);
        chk("rst_prd", 64'(o_cdb_prd), 64'd0);
        chk("rst_tag", 64'(o_cdb_rob_tag), 64'd0);
        chk("rst_fu_id", 64'(o_cdb_fu_id), 64'd0);

        // lone LSU
        fv[0] = 1'b0; fv[1] = 1'b0;
        fv[2] = 1'b1; fp[2] = 7'h12; ft[2] = 4'h3; fd[2] = 32'hDEAD_BEEF;
        step(1'b0, 1'b0);
        fv[2] = 1'b0;
        step(1'b0, 1'b0);

        // reset again so the pointer is 0, then three-way contention
        step(1'b0, 1'b1);
        for (int k = 0; k < N; k++) regen(k, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0);
            for (int k = 0; k < N; k++) if (!last_stall[k]) regen(k, 1'b1);
        end
        for (int k = 0; k < N; k++) fv[k] = 1'b0;
        step(1'b0, 1'b0);

        // pointer to 2 via a lone FU1 grant, then valid=011 wraps to FU0
        regen(1, 1'b1);
        step(1'b0, 1'b0);
        regen(0, 1'b1); regen(1, 1'b1);
        step(1'b0, 1'b0);
        regen(0, 1'b1); regen(2, 1'b1);
        step(1'b0, 1'b0);

        // flush with everyone valid, then confirm the pointer did not move
        for (int k = 0; k < N; k++) regen(k, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < N; k++) fv[k] = 1'b0;
        step(1'b0, 1'b0);

        // stream of four from FU0, one bubble, then resume
        for (int c = 0; c < 4; c++) begin
            regen(0, 1'b1);
            step(1'b0, 1'b0);
        end
        fv[0] = 1'b0;
        step(1'b0, 1'b0);
        regen(0, 1'b1);
        step(1'b0, 1'b0);
        fv[0] = 1'b0;
        step(1'b0, 1'b0);

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 2000; c++) begin
            logic fl, rs;
            for (int k = 0; k < N; k++)
                if (!last_stall[k]) regen(k, ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
            fl = ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0;
            rs = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            step(fl, rs);
        end

        // drain
        for (int k = 0; k < N; k++) fv[k] = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk); #1;
        done = 1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
